// File: rtl/blowfish_pkg.sv
// Shared Blowfish key-schedule definitions: table geometry and the loader state
// encoding used by the S-box and P-array writers.
package blowfish_pkg;

  localparam int SBOX_DEPTH = 256;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } sbox_state_t;

endpackage

// File: rtl/blowfish_sbox_writer_if.sv
// Bundle between the key scheduler / round datapath (master) and the S-box store (slave).
interface blowfish_sbox_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  // Write stream: a word transfers on a rising edge where wr_valid && wr_ready.
  // wr_ready depends only on the loader state, never on wr_valid; the master
  // holds wr_data stable while wr_valid is high and not yet accepted.
  logic              start;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              loaded;
  logic              done;
  logic [ADDR_W:0]   wr_count;

  modport master (
    output start, wr_valid, wr_data, rd_addr, rd_en,
    input  wr_ready, rd_data, rd_valid, busy, loaded, done, wr_count
  );

  modport slave (
    input  start, wr_valid, wr_data, rd_addr, rd_en,
    output wr_ready, rd_data, rd_valid, busy, loaded, done, wr_count
  );
endinterface

// File: rtl/sbox_ram.sv
// Simple dual-port S-box RAM: synchronous write, registered read returning the
// word stored before any same-edge write.
module sbox_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately outside reset so a mid-load reset keeps the partial table.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/blowfish_sbox_writer.sv
// Key-dependent Blowfish S-box store: sequential 256-word load over a valid/ready
// stream, with a one-cycle registered lookup port usable in every state.
module blowfish_sbox_writer
  import blowfish_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = $clog2(SBOX_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  blowfish_sbox_writer_if.slave  bus,
  output sbox_state_t            state_dbg
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  sbox_state_t     state, state_next;
  logic [ADDR_W:0] wr_count;
  logic            loaded;
  logic            done;
  logic            rd_valid;
  logic            wr_fire;
  logic            last_word;

  // A start in LOAD restarts the count, so the word offered on that edge is dropped.
  assign wr_fire   = (state == LOAD) && bus.wr_valid && !bus.start && !rst;
  assign last_word = (wr_count[ADDR_W-1:0] == LAST_IDX);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start) state_next = LOAD;
      LOAD: begin
        if (bus.start) begin
          state_next = LOAD;
        end else if (bus.wr_valid && last_word) begin
          state_next = DONE;
        end
      end
      DONE: if (bus.start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
      loaded   <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      done     <= wr_fire && last_word;
      rd_valid <= bus.rd_en;
      if (bus.start) begin
        wr_count <= '0;
        loaded   <= 1'b0;
      end else if (wr_fire) begin
        wr_count <= wr_count + CNT_ONE;
        if (last_word) begin
          loaded <= 1'b1;
        end
      end
    end
  end

  sbox_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_fire),
    .waddr (wr_count[ADDR_W-1:0]),
    .wdata (bus.wr_data),
    .re    (bus.rd_en),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

  assign bus.wr_ready = (state == LOAD);
  assign bus.busy     = (state == LOAD);
  assign bus.loaded   = loaded;
  assign bus.done     = done;
  assign bus.wr_count = wr_count;
  assign bus.rd_valid = rd_valid;
  assign state_dbg    = state;

endmodule

// File: tb/tb_blowfish_sbox_writer.sv
// Bench for blowfish_sbox_writer: directed load/read sequences, a read-vector
// table, and a randomized phase checked every cycle against a table model.
module tb_blowfish_sbox_writer;
  import blowfish_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = SBOX_DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  sbox_state_t state_dbg;

  always #5 clk = ~clk;

  blowfish_sbox_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  blowfish_sbox_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the table as an array plus a load cursor and a few flags.
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  int            m_cnt;
  bit            m_loading, m_loaded, m_done, m_rvalid, m_rknown;
  logic [DW-1:0] m_rdata;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_tab [DEPTH];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [6];

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int a;
    a = int'(bus.rd_addr);
    if (rst) begin
      m_cnt = 0; m_loading = 0; m_loaded = 0; m_done = 0;
      m_rvalid = 0; m_rdata = '0; m_rknown = 1;
    end else begin
      m_done = 0;
      if (bus.rd_en) begin
        m_rvalid = 1; m_rdata = m_mem[a]; m_rknown = m_known[a];
      end else begin
        m_rvalid = 0;
      end
      if (bus.start) begin
        m_loading = 1; m_loaded = 0; m_cnt = 0;
      end else if (m_loading && bus.wr_valid) begin
        m_mem[m_cnt]   = bus.wr_data;
        m_known[m_cnt] = 1;
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_loading = 0; m_loaded = 1; m_done = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("wr_ready", 32'(bus.wr_ready), 32'(m_loading));
    chk("busy",     32'(bus.busy),     32'(m_loading));
    chk("loaded",   32'(bus.loaded),   32'(m_loaded));
    chk("done",     32'(bus.done),     32'(m_done));
    chk("wr_count", 32'(bus.wr_count), 32'(m_cnt));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rvalid));
    if (m_rknown) chk("rd_data", bus.rd_data, m_rdata);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Sweeps every address, one lookup per cycle, against exp_tab.
  task automatic read_all(input string name);
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(a);
      exp_q.push_back(exp_tab[a]);
      cycle();
      chk(name, bus.rd_data, exp_q.pop_front());
    end
    bus.rd_en = 1'b0;
    cycle();
  endtask

  initial begin
    int done_cnt;
    int done_at;
    logic [DW-1:0] held;

    rst = 1'b1;
    bus.start = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;

    vecs[0] = '{8'h00, 32'h4b7a70e9};
    vecs[1] = '{8'hFF, 32'h4b7a71e8};
    vecs[2] = '{8'h01, 32'h4b7a70ea};
    vecs[3] = '{8'h10, 32'h4b7a70f9};
    vecs[4] = '{8'h7F, 32'h4b7a7168};
    vecs[5] = '{8'h80, 32'h4b7a7169};

    // Reset
    repeat (3) cycle();
    chk("reset_state", 32'(state_dbg), 32'(IDLE));
    chk("reset_rd_data", bus.rd_data, 32'h0);
    rst = 1'b0;
    cycle();

    // Full load, continuous valid
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.wr_valid = 1'b1;
    done_cnt = 0; done_at = -1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_data = 32'h4b7a70e9 + DW'(i);
      cycle();
      if (bus.done) begin done_cnt++; done_at = i + 1; end
    end
    bus.wr_valid = 1'b0;
    repeat (3) begin
      cycle();
      if (bus.done) done_cnt++;
    end
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("done_cycle", 32'(done_at), 32'd256);
    chk("loaded_after_load", 32'(bus.loaded), 32'd1);
    chk("state_done", 32'(state_dbg), 32'(DONE));

    // Table-driven lookups: latency 1, data holds when rd_en drops
    foreach (vecs[k]) begin
      bus.rd_en = 1'b1;
      bus.rd_addr = vecs[k].addr;
      cycle();
      chk("vec_rd_valid", 32'(bus.rd_valid), 32'd1);
      chk("vec_rd_data", bus.rd_data, vecs[k].exp);
      held = bus.rd_data;
      bus.rd_en = 1'b0;
      bus.rd_addr = ~vecs[k].addr;
      cycle();
      chk("vec_rd_valid_drop", 32'(bus.rd_valid), 32'd0);
      chk("vec_rd_hold", bus.rd_data, vecs[k].exp);
    end

    // Writes offered in DONE are ignored
    bus.wr_valid = 1'b1;
    bus.wr_data = 32'hDEADBEEF;
    cycle();
    chk("done_wr_ready", 32'(bus.wr_ready), 32'd0);
    for (int i = 0; i < DEPTH; i++) exp_tab[i] = 32'h4b7a70e9 + DW'(i);
    read_all("done_table_unchanged");
    bus.wr_valid = 1'b0;

    // Load with wr_valid toggling; invalid cycles carry junk
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    for (int j = 0; j < 2 * DEPTH - 1; j++) begin
      bus.wr_valid = (j % 2 == 0);
      bus.wr_data  = $urandom;
      if (j % 2 == 0) exp_tab[j / 2] = bus.wr_data;
      cycle();
    end
    chk("toggle_count", 32'(bus.wr_count), 32'd256);
    chk("toggle_done", 32'(bus.done), 32'd1);
    bus.wr_valid = 1'b0;
    read_all("toggle_table");

    // Restart mid-load at count 100
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.wr_data = 32'h12340000 + DW'(i);
      cycle();
    end
    chk("restart_count_before", 32'(bus.wr_count), 32'd100);
    bus.start = 1'b1;
    bus.wr_data = 32'hBAD0BAD0;
    cycle();
    bus.start = 1'b0;
    chk("restart_count_zero", 32'(bus.wr_count), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_data = 32'hA5A50000 + DW'(i);
      cycle();
    end
    bus.wr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_tab[i] = 32'hA5A50000 + DW'(i);
    read_all("restart_table");

    // Same-cycle write and read of index 0x10
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_data = 32'h22220000 + DW'(i);
      cycle();
    end
    bus.wr_data = 32'h11111111;
    bus.rd_en = 1'b1;
    bus.rd_addr = 8'h10;
    cycle();
    chk("raw_old_word", bus.rd_data, 32'hA5A50010);
    bus.wr_valid = 1'b0;
    cycle();
    chk("raw_new_word", bus.rd_data, 32'h11111111);
    bus.rd_en = 1'b0;

    // Reset at count 50, with start asserted on the same edge
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    bus.wr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      bus.wr_data = 32'h50500000 + DW'(i);
      cycle();
    end
    chk("rst_count_before", 32'(bus.wr_count), 32'd50);
    rst = 1'b1;
    bus.start = 1'b1;
    bus.wr_data = 32'hFFFFFFFF;
    cycle();
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_state_idle", 32'(state_dbg), 32'(IDLE));
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_loaded", 32'(bus.loaded), 32'd0);
    cycle();
    chk("rst_idle_ignores_valid", 32'(bus.wr_count), 32'd0);
    bus.wr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      exp_tab[i] = (i < 50) ? 32'h50500000 + DW'(i) : 32'hA5A50000 + DW'(i);
    read_all("rst_partial_table");

    // Randomized traffic against the model
    bus.start = 1'b1;
    cycle();
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 999) == 0);
      bus.start    = ($urandom_range(0, 399) == 0);
      bus.wr_valid = ($urandom_range(0, 3) != 0);
      bus.wr_data  = $urandom;
      bus.rd_en    = ($urandom_range(0, 1) == 1);
      bus.rd_addr  = AW'($urandom_range(0, DEPTH - 1));
      cycle();
    end
    rst = 1'b0; bus.start = 1'b0; bus.wr_valid = 1'b0; bus.rd_en = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
